// File: rtl/pkt_buf_ctrl.sv
// Packet-buffer controller: writes beats into a circular reg_file buffer,
// commits or drops whole packets, and replays committed packets downstream.
module pkt_buf_ctrl #(
  parameter int pDATA_WIDTH = 8,
  parameter int pDEPTH_RAM  = 64,
  parameter int pMAX_PKTS   = 8
) (
  input  logic                          iclk,
  input  logic                          irst,
  input  logic                          ivalid,
  input  logic [pDATA_WIDTH-1:0]        idata,
  input  logic                          ilast,
  output logic                          owr_en,
  output logic [$clog2(pDEPTH_RAM)-1:0] ow_addr,
  output logic [pDATA_WIDTH-1:0]        ow_data,
  output logic [$clog2(pDEPTH_RAM)-1:0] or_addr,
  input  logic [pDATA_WIDTH-1:0]        ir_data,
  output logic                          ovalid,
  output logic [pDATA_WIDTH-1:0]        odata,
  output logic                          olast,
  input  logic                          iready,
  output logic                          odrop,
  output logic [$clog2(pMAX_PKTS):0]    opkt_cnt,
  output logic [$clog2(pDEPTH_RAM):0]   ofree
);
  localparam int AW = $clog2(pDEPTH_RAM);
  localparam int QW = $clog2(pMAX_PKTS);
  localparam logic [AW:0] DEPTH = (AW+1)'(pDEPTH_RAM);
  localparam logic [QW:0] QMAX  = (QW+1)'(pMAX_PKTS);
  localparam logic [AW:0] ONE   = (AW+1)'(1);
  localparam logic [QW-1:0] QONE = QW'(1);
  localparam logic [QW:0] CONE  = (QW+1)'(1);

  typedef enum logic [1:0] {WR_IDLE, WR_PKT, WR_DROP} wr_st_t;

  wr_st_t        wr_st;
  logic [AW:0]   wr_ptr, wr_start, rd_rel, rd_iss;
  logic [AW:0]   end_q [pMAX_PKTS];
  logic [QW-1:0] q_tail, iss_idx;
  logic          rd_pend, pend_last;
  logic          skid_v, skid_last;
  logic [pDATA_WIDTH-1:0] skid_data;

  logic [AW:0] used, wr_ptr_nx, rd_rel_nx;
  logic        wr_act, drop_now, commit;
  logic        pop, pop_pkt, issue, iss_last;
  logic [1:0]  occ;

  // occ: entries that will sit in out+skid once this cycle's pop retires
  always_comb begin
    used      = wr_ptr - rd_rel;
    wr_act    = ivalid && (wr_st != WR_DROP);
    drop_now  = wr_act && ((used == DEPTH) ||
                (ilast && (opkt_cnt == QMAX)));
    owr_en    = wr_act && !drop_now;
    commit    = owr_en && ilast;
    pop       = ovalid && iready;
    pop_pkt   = pop && olast;
    occ       = 2'(ovalid) + 2'(skid_v) + 2'(rd_pend) - 2'(pop);
    issue     = (rd_iss != wr_start) && (occ <= 2'd1);
    iss_last  = (rd_iss + ONE) == end_q[iss_idx];
    wr_ptr_nx = drop_now ? wr_start :
                (owr_en ? wr_ptr + ONE : wr_ptr);
    rd_rel_nx = rd_rel + (AW+1)'(pop);
  end

  assign ow_addr = wr_ptr[AW-1:0];
  assign ow_data = idata;
  assign or_addr = rd_iss[AW-1:0];

  always_ff @(posedge iclk) begin
    if (commit) end_q[q_tail] <= wr_ptr + ONE;
  end

  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      wr_st    <= WR_IDLE;
      wr_ptr   <= '0;
      wr_start <= '0;
      q_tail   <= '0;
      odrop    <= 1'b0;
      opkt_cnt <= '0;
      ofree    <= DEPTH;
    end else begin
      odrop  <= drop_now;
      wr_ptr <= wr_ptr_nx;
      ofree  <= DEPTH - (wr_ptr_nx - rd_rel_nx);
      if (commit) begin
        wr_start <= wr_ptr + ONE;
        q_tail   <= q_tail + QONE;
      end
      unique case ({commit, pop_pkt})
        2'b10:   opkt_cnt <= opkt_cnt + CONE;
        2'b01:   opkt_cnt <= opkt_cnt - CONE;
        default: ;
      endcase
      unique case (wr_st)
        WR_IDLE, WR_PKT:
          if (ivalid)
            wr_st <= ilast ? WR_IDLE :
                     (drop_now ? WR_DROP : WR_PKT);
        WR_DROP:
          if (ivalid && ilast) wr_st <= WR_IDLE;
        default: wr_st <= WR_IDLE;
      endcase
    end
  end

  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      rd_iss    <= '0;
      rd_rel    <= '0;
      iss_idx   <= '0;
      rd_pend   <= 1'b0;
      pend_last <= 1'b0;
      skid_v    <= 1'b0;
      skid_last <= 1'b0;
      skid_data <= '0;
      ovalid    <= 1'b0;
      olast     <= 1'b0;
      odata     <= '0;
    end else begin
      rd_rel    <= rd_rel_nx;
      rd_pend   <= issue;
      pend_last <= iss_last;
      if (issue) begin
        rd_iss <= rd_iss + ONE;
        if (iss_last) iss_idx <= iss_idx + QONE;
      end
      if (pop || !ovalid) begin
        if (skid_v) begin
          ovalid    <= 1'b1;
          odata     <= skid_data;
          olast     <= skid_last;
          skid_v    <= rd_pend;
          skid_data <= ir_data;
          skid_last <= pend_last;
        end else begin
          ovalid <= rd_pend;
          olast  <= rd_pend && pend_last;
          if (rd_pend) odata <= ir_data;
        end
      end else if (rd_pend) begin
        skid_v    <= 1'b1;
        skid_data <= ir_data;
        skid_last <= pend_last;
      end
    end
  end
endmodule

// File: tb/tb_pkt_buf_ctrl.sv
// Bench for pkt_buf_ctrl: reg_file model, packet-level scoreboard,
// table vectors and directed corner sequences.
module tb_pkt_buf_ctrl;
  localparam int DW = 8;
  localparam int DEPTH = 16;
  localparam int MAXP = 4;
  localparam int AW = 4;

  logic iclk = 1'b0;
  logic irst, ivalid, ilast, iready;
  logic [DW-1:0] idata, ir_data, odata, ow_data;
  logic owr_en, ovalid, olast, odrop;
  logic [AW-1:0] ow_addr, or_addr;
  logic [2:0] opkt_cnt;
  logic [AW:0] ofree;
  logic [DW-1:0] ram [DEPTH];

  pkt_buf_ctrl #(
    .pDATA_WIDTH(DW), .pDEPTH_RAM(DEPTH), .pMAX_PKTS(MAXP)
  ) dut (
    .iclk(iclk), .irst(irst), .ivalid(ivalid), .idata(idata),
    .ilast(ilast), .owr_en(owr_en), .ow_addr(ow_addr),
    .ow_data(ow_data), .or_addr(or_addr), .ir_data(ir_data),
    .ovalid(ovalid), .odata(odata), .olast(olast),
    .iready(iready), .odrop(odrop), .opkt_cnt(opkt_cnt),
    .ofree(ofree)
  );

  always #5 iclk = ~iclk;

  always_ff @(posedge iclk) begin
    if (owr_en) ram[ow_addr] <= ow_data;
    ir_data <= ram[or_addr];
  end

  typedef struct packed {logic [7:0] d; logic l;} beat_t;
  typedef struct {
    logic v; logic [7:0] d; logic l; logic r;
    logic ev; logic [7:0] ed; logic el; int ec;
  } vec_t;

  int checks = 0, errors = 0;
  beat_t expq[$];
  logic [7:0] cur[$];
  int m_used, m_qcnt, m_wptr;
  bit m_dropping, m_drop_exp, prev_stall;
  beat_t prev_out;
  int pops, drops_seen, cyc, rmode;
  bit saw_wrap, any_wr;
  logic [AW-1:0] last_waddr;
  bit pat[6] = '{1, 0, 0, 1, 0, 1};

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d t=%0t",
               name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    expq.delete();
    cur.delete();
    m_used = 0; m_qcnt = 0; m_wptr = 0;
    m_dropping = 0; m_drop_exp = 0; prev_stall = 0;
  endtask

  // Packet-level reference: occupancy counters plus expected beat queue
  task automatic model_pre();
    int u0, q0;
    beat_t b;
    u0 = m_used;
    q0 = m_qcnt;
    if (prev_stall) begin
      chk("hold_valid", ovalid, 1);
      chk("hold_data", odata, prev_out.d);
      chk("hold_last", olast, prev_out.l);
    end
    if (ovalid) chk("out_avail", int'(expq.size() > 0), 1);
    if (ovalid && iready && expq.size() > 0) begin
      b = expq.pop_front();
      chk("out_data", odata, b.d);
      chk("out_last", olast, b.l);
      m_used--;
      if (b.l) m_qcnt--;
      pops++;
    end
    m_drop_exp = 0;
    if (!ivalid) chk("wr_idle", owr_en, 0);
    else if (m_dropping) begin
      chk("wr_ign", owr_en, 0);
      if (ilast) m_dropping = 0;
    end else if (u0 == DEPTH || (ilast && q0 == MAXP)) begin
      chk("wr_drop", owr_en, 0);
      m_drop_exp = 1;
      m_used -= cur.size();
      m_wptr -= cur.size();
      cur.delete();
      m_dropping = !ilast;
    end else begin
      chk("wr_en", owr_en, 1);
      chk("wr_addr", ow_addr, m_wptr % DEPTH);
      chk("wr_data", ow_data, idata);
      if (any_wr && last_waddr == 4'd15 && ow_addr == 4'd0)
        saw_wrap = 1;
      any_wr = 1;
      last_waddr = ow_addr;
      cur.push_back(idata);
      m_used++;
      m_wptr++;
      if (ilast) begin
        foreach (cur[i]) expq.push_back({cur[i], i == cur.size() - 1});
        cur.delete();
        m_qcnt++;
      end
    end
    prev_stall = ovalid && !iready;
    prev_out = {odata, olast};
  endtask

  task automatic model_post();
    chk("odrop", odrop, m_drop_exp);
    chk("pkt_cnt", opkt_cnt, m_qcnt);
    chk("ofree", ofree, DEPTH - m_used);
    if (odrop) drops_seen++;
  endtask

  task automatic tick();
    case (rmode)
      1: iready = pat[cyc % 6];
      2: iready = ($urandom_range(0, 99) < 70);
      default: ;
    endcase
    cyc++;
    #3;
    model_pre();
    @(posedge iclk);
    #1;
    model_post();
  endtask

  task automatic do_reset(bit async_chk);
    irst = 1; ivalid = 0; ilast = 0; idata = 0; iready = 0;
    if (async_chk) begin
      #2;
      chk("arst_ovalid", ovalid, 0);
      chk("arst_cnt", opkt_cnt, 0);
      chk("arst_free", ofree, DEPTH);
      chk("arst_wr_en", owr_en, 0);
    end
    @(posedge iclk);
    #1;
    chk("rst_ovalid", ovalid, 0);
    chk("rst_olast", olast, 0);
    chk("rst_odrop", odrop, 0);
    chk("rst_odata", odata, 0);
    chk("rst_cnt", opkt_cnt, 0);
    chk("rst_free", ofree, DEPTH);
    chk("rst_waddr", ow_addr, 0);
    irst = 0;
    model_reset();
  endtask

  task automatic send_pkt(int len, int base);
    for (int i = 0; i < len; i++) begin
      ivalid = 1;
      idata = 8'(base + i);
      ilast = (i == len - 1);
      tick();
    end
    ivalid = 0;
    ilast = 0;
  endtask

  task automatic send_rand(int len, int base);
    for (int i = 0; i < len; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        ivalid = 0; ilast = 0;
        tick();
      end
      ivalid = 1;
      idata = 8'(base + i);
      ilast = (i == len - 1);
      tick();
    end
    ivalid = 0;
    ilast = 0;
  endtask

  task automatic drain(string name, int budget);
    ivalid = 0;
    ilast = 0;
    for (int i = 0; i < budget && expq.size() != 0; i++) tick();
    chk(name, expq.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tv[10];
    int p0, d0;
    tv[0] = '{1, 8'd11, 0, 1, 0, 8'd0, 0, 0};
    tv[1] = '{1, 8'd12, 0, 1, 0, 8'd0, 0, 0};
    tv[2] = '{1, 8'd13, 0, 1, 0, 8'd0, 0, 0};
    tv[3] = '{1, 8'd14, 1, 1, 0, 8'd0, 0, 1};
    tv[4] = '{0, 8'd0, 0, 1, 0, 8'd0, 0, 1};
    tv[5] = '{0, 8'd0, 0, 1, 1, 8'd11, 0, 1};
    tv[6] = '{0, 8'd0, 0, 1, 1, 8'd12, 0, 1};
    tv[7] = '{0, 8'd0, 0, 1, 1, 8'd13, 0, 1};
    tv[8] = '{0, 8'd0, 0, 1, 1, 8'd14, 1, 1};
    tv[9] = '{0, 8'd0, 0, 1, 0, 8'd0, 0, 0};
    pops = 0; drops_seen = 0; cyc = 0; rmode = 0;
    saw_wrap = 0; any_wr = 0; last_waddr = '0;
    model_reset();
    do_reset(0);

    for (int k = 0; k < 10; k++) begin
      ivalid = tv[k].v; idata = tv[k].d;
      ilast = tv[k].l; iready = tv[k].r;
      tick();
      chk("tv_valid", ovalid, tv[k].ev);
      if (tv[k].ev) begin
        chk("tv_data", odata, tv[k].ed);
        chk("tv_last", olast, tv[k].el);
      end
      chk("tv_cnt", opkt_cnt, tv[k].ec);
    end

    // stalled consumer
    rmode = 1;
    p0 = pops;
    send_pkt(8, 8'h30);
    drain("t2_drain", 100);
    chk("t2_beats", pops - p0, 8);

    // overflow of a second packet while the first sits unread
    rmode = 0;
    iready = 0;
    send_pkt(12, 8'h40);
    for (int i = 0; i < 6; i++) begin
      ivalid = 1;
      idata = 8'(8'h60 + i);
      ilast = (i == 5);
      tick();
      if (i == 4) chk("t3_odrop", odrop, 1);
    end
    ivalid = 0; ilast = 0;
    chk("t3_free", ofree, 4);
    send_pkt(3, 8'h70);
    chk("t3_cnt", opkt_cnt, 2);
    iready = 1;
    p0 = pops;
    for (int i = 0; i < 15; i++) begin
      chk("t3_nobubble", ovalid, 1);
      tick();
    end
    chk("t3_beats", pops - p0, 15);
    drain("t3_drain", 10);

    // back-to-back packets across the address wrap
    iready = 1;
    p0 = pops;
    d0 = drops_seen;
    saw_wrap = 0;
    for (int p = 0; p < 20; p++) send_pkt(5, p * 5);
    drain("t4_drain", 100);
    chk("t4_beats", pops - p0, 100);
    chk("t4_drops", drops_seen - d0, 0);
    chk("t4_wrap", saw_wrap, 1);

    // end-pointer queue full
    iready = 0;
    for (int p = 0; p < 5; p++) send_pkt(1, 8'h80 + p);
    chk("t5_odrop", odrop, 1);
    chk("t5_cnt", opkt_cnt, 4);
    iready = 1;
    p0 = pops;
    drain("t5_drain", 20);
    chk("t5_beats", pops - p0, 4);

    // randomized traffic
    rmode = 2;
    for (int p = 0; p < 60; p++) begin
      send_rand($urandom_range(1, 20), $urandom_range(0, 255));
      repeat ($urandom_range(0, 3)) tick();
    end
    rmode = 0;
    iready = 1;
    drain("rnd_drain", 300);

    // reset mid-write
    ivalid = 1; ilast = 0; idata = 8'h11;
    tick();
    tick();
    do_reset(1);
    // reset mid-output
    iready = 1;
    send_pkt(4, 8'h90);
    for (int i = 0; i < 10 && !ovalid; i++) tick();
    chk("t6_started", ovalid, 1);
    tick();
    do_reset(1);
    iready = 1;
    ivalid = 1; idata = 8'hA0; ilast = 0;
    #1;
    chk("t6_addr0", ow_addr, 0);
    chk("t6_wr_en", owr_en, 1);
    p0 = pops;
    send_pkt(4, 8'hA0);
    drain("t6_drain", 20);
    chk("t6_beats", pops - p0, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
